data_memory_responder: RTL and testbench

- Memory-side responder for the cache/core memory port.
- Accepts a byte address, a 4-byte big-endian write lane array and a write enable from the cache.
- Returns the addressed word on a 4-byte lane array after a programmable access latency, and flags readiness once the address has been stable long enough.
- Replaces the zero-latency behavioural memory in system-level simulation, so cache stall and refill paths are exercised with realistic timing.

---
 rtl/data_memory_responder.sv | 100 ++++++++++
 tb/tb_data_memory_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Memory-side responder: byte-addressed store returning a big-endian word only
// after the word address has been stable for LATENCY cycles.
module data_memory_responder #(
  parameter int MEM_BYTES = 65536,
  parameter int LATENCY   = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data_in [0:3],
  input  logic              mem_write_en,
  output logic [7:0]        mem_data_out [0:3],
  output logic              mem_ready,
  output logic              oob_error,
  output logic [31:0]       read_count,
  output logic [31:0]       write_count
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam logic [3:0] FETCH_CNT = 4'(LATENCY - 1);
  localparam logic [3:0] READY_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {ST_WAIT, ST_FETCH, ST_READY} state_e;

  logic [7:0]        storeQ [MEM_BYTES];
  logic [ADDR_W-3:0] addr_q;
  logic [ADDR_W-3:0] waddr;
  logic [3:0]        cnt_q, cnt_d;
  logic              start_q;
  logic              changed;
  logic              inRange;
  logic [IDX_W-1:0]  baseIdx;
  state_e            state;

  assign waddr   = mem_addr[ADDR_W-1:2];
  assign inRange = mem_addr < ADDR_W'(MEM_BYTES);
  assign baseIdx = {mem_addr[IDX_W-1:2], 2'b00};
  // start_q makes the first cycle out of reset restart the access
  assign changed = (waddr != addr_q) || mem_write_en || start_q;

  always_comb begin
    state = ST_WAIT;
    cnt_d = cnt_q;
    if (cnt_q == READY_CNT) begin
      state = ST_READY;
    end else if (cnt_q == FETCH_CNT && !changed) begin
      state = ST_FETCH;
    end
    if (changed) begin
      cnt_d = 4'd0;
    end else if (cnt_q < READY_CNT) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      cnt_q       <= 4'd0;
      start_q     <= 1'b1;
      mem_ready   <= 1'b0;
      oob_error   <= 1'b0;
      read_count  <= 32'd0;
      write_count <= 32'd0;
      for (int i = 0; i < 4; i++) mem_data_out[i] <= 8'h00;
    end else begin
      start_q <= 1'b0;
      addr_q  <= waddr;
      cnt_q   <= cnt_d;
      if (changed) begin
        mem_ready <= 1'b0;
      end else if (state == ST_FETCH) begin
        mem_ready  <= 1'b1;
        read_count <= read_count + 32'd1;
        if (inRange) begin
          for (int i = 0; i < 4; i++) mem_data_out[i] <= storeQ[baseIdx | IDX_W'(i)];
        end else begin
          for (int i = 0; i < 4; i++) mem_data_out[i] <= 8'h00;
          oob_error <= 1'b1;
        end
      end
      if (mem_write_en) begin
        if (inRange) begin
          write_count <= write_count + 32'd1;
        end else begin
          oob_error <= 1'b1;
        end
      end
    end
  end

  // Store is never cleared; a write coinciding with reset is discarded
  always_ff @(posedge clk) begin
    if (!reset && mem_write_en && inRange) begin
      for (int i = 0; i < 4; i++) storeQ[baseIdx | IDX_W'(i)] <= mem_data_in[i];
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: LATENCY=4 instance plus a LATENCY=1 instance.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset, rst1;
  logic [31:0] mem_addr, addr1;
  logic [7:0]  din [0:3];
  logic [7:0]  din1 [0:3];
  logic        we, we1;
  logic [7:0]  dout [0:3];
  logic [7:0]  dout1 [0:3];
  logic        ready, ready1, oob, oob1;
  logic [31:0] rc, wc, rc1, wc1;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.MEM_BYTES(65536), .LATENCY(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data_in(din),
    .mem_write_en(we), .mem_data_out(dout), .mem_ready(ready),
    .oob_error(oob), .read_count(rc), .write_count(wc)
  );

  data_memory_responder #(.MEM_BYTES(65536), .LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(rst1), .mem_addr(addr1), .mem_data_in(din1),
    .mem_write_en(we1), .mem_data_out(dout1), .mem_ready(ready1),
    .oob_error(oob1), .read_count(rc1), .write_count(wc1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w);
    mem_addr = a;
    {din[0], din[1], din[2], din[3]} = w;
    we = 1'b1;
    step(1);
    we = 1'b0;
  endtask

  task automatic applyStimulus1(input logic [31:0] a, input logic [31:0] w);
    addr1 = a;
    {din1[0], din1[1], din1[2], din1[3]} = w;
    we1 = 1'b1;
    step(1);
    we1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rst1 = 1'b1; we = 1'b0; we1 = 1'b0;
    mem_addr = 32'h0; addr1 = 32'h0;
    for (int i = 0; i < 4; i++) begin din[i] = 8'h00; din1[i] = 8'h00; end
    step(2);
    reset = 1'b0; rst1 = 1'b0;

    // Preload backing stores through the write port, then reset the counters
    applyStimulus(32'h0, 32'h01020304);
    applyStimulus(32'h10, 32'hDEADBEEF);
    applyStimulus(32'h14, 32'h55667788);
    applyStimulus1(32'h0, 32'h01020304);
    applyStimulus1(32'h4, 32'hA0A1A2A3);
    applyStimulus1(32'h8, 32'hB0B1B2B3);
    reset = 1'b1; rst1 = 1'b1;
    #1;
    checkOutput("rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("rst_lanes", {dout[0], dout[1], dout[2], dout[3]}, 32'h0);
    checkOutput("rst_oob", {31'd0, oob}, 32'd0);
    checkOutput("rst_rc", rc, 32'd0);
    checkOutput("rst_wc", wc, 32'd0);
    checkOutput("rst1_wc", wc1, 32'd0);
    step(1);

    // First read of 0x10
    reset = 1'b0;
    mem_addr = 32'h10;
    step(4);
    checkOutput("t1_not_ready", {31'd0, ready}, 32'd0);
    step(1);
    checkOutput("t1_ready", {31'd0, ready}, 32'd1);
    checkOutput("t1_lanes", {dout[0], dout[1], dout[2], dout[3]}, 32'hDEADBEEF);
    checkOutput("t1_rc", rc, 32'd1);

    // Write then read back same address
    applyStimulus(32'h20, 32'h11223344);
    checkOutput("t2_wc", wc, 32'd1);
    checkOutput("t2_ready_low", {31'd0, ready}, 32'd0);
    step(3);
    checkOutput("t2_still_low", {31'd0, ready}, 32'd0);
    step(1);
    checkOutput("t2_ready", {31'd0, ready}, 32'd1);
    checkOutput("t2_lanes", {dout[0], dout[1], dout[2], dout[3]}, 32'h11223344);
    checkOutput("t2_rc", rc, 32'd2);

    // Address changes: 0x10, hold, 0x14, back to 0x10
    mem_addr = 32'h10;
    step(4);
    checkOutput("t3_a_low", {31'd0, ready}, 32'd0);
    step(1);
    checkOutput("t3_a_lanes", {dout[0], dout[1], dout[2], dout[3]}, 32'hDEADBEEF);
    step(2);
    checkOutput("t3_hold_ready", {31'd0, ready}, 32'd1);
    checkOutput("t3_no_recount", rc, 32'd3);
    mem_addr = 32'h14;
    step(1);
    checkOutput("t3_drop", {31'd0, ready}, 32'd0);
    checkOutput("t3_hold_lanes", {dout[0], dout[1], dout[2], dout[3]}, 32'hDEADBEEF);
    step(3);
    checkOutput("t3_b_low", {31'd0, ready}, 32'd0);
    step(1);
    checkOutput("t3_b_lanes", {dout[0], dout[1], dout[2], dout[3]}, 32'h55667788);
    mem_addr = 32'h10;
    step(1);
    checkOutput("t3_drop2", {31'd0, ready}, 32'd0);
    step(4);
    checkOutput("t3_c_lanes", {dout[0], dout[1], dout[2], dout[3]}, 32'hDEADBEEF);
    checkOutput("t3_rc", rc, 32'd5);

    // Out-of-range read and write
    mem_addr = 32'h0001_0000;
    step(5);
    checkOutput("t4_ready", {31'd0, ready}, 32'd1);
    checkOutput("t4_lanes", {dout[0], dout[1], dout[2], dout[3]}, 32'h0);
    checkOutput("t4_oob", {31'd0, oob}, 32'd1);
    checkOutput("t4_rc", rc, 32'd6);
    applyStimulus(32'h0001_0000, 32'hAABBCCDD);
    checkOutput("t4_wc", wc, 32'd1);
    mem_addr = 32'h0;
    step(5);
    checkOutput("t4_store_kept", {dout[0], dout[1], dout[2], dout[3]}, 32'h01020304);
    checkOutput("t4_oob_sticky", {31'd0, oob}, 32'd1);
    checkOutput("t4_rc2", rc, 32'd7);

    // Reset during FETCH, with a write in flight on a reset edge
    mem_addr = 32'h10;
    step(4);
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("t5_rst_rc", rc, 32'd0);
    checkOutput("t5_rst_oob", {31'd0, oob}, 32'd0);
    {din[0], din[1], din[2], din[3]} = 32'h99999999;
    we = 1'b1;
    step(1);
    we = 1'b0;
    reset = 1'b0;
    step(4);
    checkOutput("t5_low", {31'd0, ready}, 32'd0);
    step(1);
    checkOutput("t5_ready", {31'd0, ready}, 32'd1);
    checkOutput("t5_lanes", {dout[0], dout[1], dout[2], dout[3]}, 32'hDEADBEEF);
    checkOutput("t5_rc", rc, 32'd1);
    checkOutput("t5_wc", wc, 32'd0);

    // LATENCY=1 instance: each address held two cycles
    addr1 = 32'h0;
    rst1 = 1'b0;
    step(1);
    checkOutput("t6_a_low", {31'd0, ready1}, 32'd0);
    step(1);
    checkOutput("t6_a_ready", {31'd0, ready1}, 32'd1);
    checkOutput("t6_a_lanes", {dout1[0], dout1[1], dout1[2], dout1[3]}, 32'h01020304);
    addr1 = 32'h4;
    step(1);
    checkOutput("t6_b_low", {31'd0, ready1}, 32'd0);
    step(1);
    checkOutput("t6_b_lanes", {dout1[0], dout1[1], dout1[2], dout1[3]}, 32'hA0A1A2A3);
    addr1 = 32'h8;
    step(1);
    checkOutput("t6_c_low", {31'd0, ready1}, 32'd0);
    step(1);
    checkOutput("t6_c_ready", {31'd0, ready1}, 32'd1);
    checkOutput("t6_c_lanes", {dout1[0], dout1[1], dout1[2], dout1[3]}, 32'hB0B1B2B3);
    checkOutput("t6_rc", rc1, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
